// File: rtl/bus_arb_2023211063.sv
// Three-master / one-slave bus arbiter: fixed priority m0 > m1 > m2 with
// starvation escape for m2, single-outstanding transaction, timeout abort.

module bus_arb_2023211063_mport (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_i,
  input  logic        sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o
);
  logic [31:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (cap_i) data_d = data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data_o = data_q;
  assign ack_o  = sel_i;
endmodule

module bus_arb_2023211063 #(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_data_i,
  output logic [31:0] m0_data_o,
  output logic        m0_ack_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_data_i,
  output logic [31:0] m1_data_o,
  output logic        m1_ack_o,
  input  logic        m2_req_i,
  input  logic [31:0] m2_addr_i,
  output logic [31:0] m2_data_o,
  output logic        m2_ack_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_data_o,
  input  logic [31:0] s_data_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        hold_flag_o,
  output logic        err_o
);
  localparam int NUM_M = 3;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [3:0]  starve_q, starve_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        err_q, err_d;

  logic [NUM_M-1:0]  req;
  logic [3:0][31:0]  m_addr;
  logic [3:0][31:0]  m_wdata;
  logic [3:0]        m_we;
  logic [1:0]        win;
  logic [31:0]       rsp_data;
  logic              rsp_cap;

  assign req     = {m2_req_i, m1_req_i, m0_req_i};
  // Entry 3 is a dummy so the winner index never selects out of range.
  assign m_addr  = {32'd0, m2_addr_i, m1_addr_i, m0_addr_i};
  assign m_wdata = {32'd0, 32'd0, m1_data_i, m0_data_i};
  assign m_we    = {1'b0, 1'b0, m1_we_i, m0_we_i};

  always_comb begin
    win = 2'd2;
    if (req[2] && starve_q == STARVE_MAX) win = 2'd2;
    else if (req[0])                      win = 2'd0;
    else if (req[1])                      win = 2'd1;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    starve_d = starve_q;
    timer_d  = timer_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    err_d    = err_q;
    rsp_data = s_data_i;
    rsp_cap  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_BUSY;
          grant_d = win;
          addr_d  = m_addr[win];
          wdata_d = m_wdata[win];
          we_d    = m_we[win];
          timer_d = '0;
          err_d   = 1'b0;
          if (req[2] && win != 2'd2)
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
          else
            starve_d = '0;
        end
      end
      ST_BUSY: begin
        // A slave ack in the timeout cycle still completes normally.
        if (s_ack_i) begin
          state_d  = ST_RESP;
          rsp_cap  = 1'b1;
          err_d    = 1'b0;
        end else if (timer_q == TMO_LAST) begin
          state_d  = ST_RESP;
          rsp_cap  = 1'b1;
          rsp_data = '0;
          err_d    = 1'b1;
        end else begin
          timer_d  = timer_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= GNT_NONE;
      starve_q <= '0;
      timer_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      starve_q <= starve_d;
      timer_q  <= timer_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  logic [NUM_M-1:0][31:0] m_rdata;
  logic [NUM_M-1:0]       m_ack;

  for (genvar g = 0; g < NUM_M; g++) begin : g_port
    bus_arb_2023211063_mport u_port (
      .clk    (clk),
      .rst    (rst),
      .cap_i  (rsp_cap && grant_q == 2'(g)),
      .sel_i  (state_q == ST_RESP && grant_q == 2'(g)),
      .data_i (rsp_data),
      .data_o (m_rdata[g]),
      .ack_o  (m_ack[g])
    );
  end

  assign m0_data_o = m_rdata[0];
  assign m1_data_o = m_rdata[1];
  assign m2_data_o = m_rdata[2];
  assign m0_ack_o  = m_ack[0];
  assign m1_ack_o  = m_ack[1];
  assign m2_ack_o  = m_ack[2];

  assign s_req_o     = (state_q == ST_BUSY);
  assign s_we_o      = s_req_o & we_q;
  assign s_addr_o    = addr_q;
  assign s_data_o    = wdata_q;
  assign grant_o     = grant_q;
  assign err_o       = (state_q == ST_RESP) & err_q;
  assign hold_flag_o = m0_req_i | m1_req_i | (state_q != ST_IDLE && grant_q != 2'd2);
endmodule

// File: tb/tb_bus_arb_2023211063.sv
// Directed bench for bus_arb_2023211063: table of arbitration vectors plus
// timeout, starvation and reset corner sequences.

module tb_bus_arb_2023211063;
  localparam int TMO = 255;
  localparam logic [31:0] A0 = 32'hA000_0010, A1 = 32'h1000_0004, A2 = 32'h2000_0008;
  localparam logic [31:0] W0 = 32'h0BAD_C0DE, W1 = 32'h1111_2222;

  logic clk = 1'b0, rst;
  logic m0_req_i, m0_we_i, m1_req_i, m1_we_i, m2_req_i, s_ack_i;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i, m2_addr_i, s_data_i;
  logic [31:0] m0_data_o, m1_data_o, m2_data_o, s_addr_o, s_data_o;
  logic m0_ack_o, m1_ack_o, m2_ack_o, s_req_o, s_we_o, hold_flag_o, err_o;
  logic [1:0] grant_o;

  int checks = 0, errors = 0;
  logic [31:0] exp_data [3];

  bus_arb_2023211063 #(.STARVE_LIMIT(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i),
    .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i),
    .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o),
    .m2_req_i(m2_req_i), .m2_addr_i(m2_addr_i), .m2_data_o(m2_data_o), .m2_ack_o(m2_ack_o),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .hold_flag_o(hold_flag_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [31:0] rdata;
    logic [1:0]  gnt;
    int          ack;
  } vec_t;
  vec_t tbl [8];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [1:0] g);
    return (g == 2'd0) ? A0 : (g == 2'd1) ? A1 : A2;
  endfunction

  function automatic logic [31:0] wdata_of(input logic [1:0] g);
    return (g == 2'd0) ? W0 : (g == 2'd1) ? W1 : 32'd0;
  endfunction

  task automatic restore_masters();
    m0_addr_i = A0; m0_data_i = W0; m0_we_i = 1'b1;
    m1_addr_i = A1; m1_data_i = W1; m1_we_i = 1'b0;
    m2_addr_i = A2;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_gnt"}, 32'(grant_o), 32'd3);
    chk({nm, "_sreq"}, 32'(s_req_o), 32'd0);
    chk({nm, "_acks"}, 32'({m2_ack_o, m1_ack_o, m0_ack_o}), 32'd0);
    chk({nm, "_err"}, 32'(err_o), 32'd0);
  endtask

  // One full transaction; ack_cyc = BUSY cycle of the slave ack, 0 = never.
  task automatic run_txn(input logic [2:0] mask, input logic [31:0] rdata,
                         input logic [1:0] eg, input int ack_cyc, input string nm);
    int len, bad;
    logic timed;
    logic [31:0] rd;
    m0_req_i = mask[0]; m1_req_i = mask[1]; m2_req_i = mask[2];
    #1;
    chk({nm, "_hold_idle"}, 32'(hold_flag_o), 32'(mask[0] | mask[1]));
    tick();
    chk({nm, "_gnt"}, 32'(grant_o), 32'(eg));
    chk({nm, "_saddr"}, s_addr_o, addr_of(eg));
    chk({nm, "_swe"}, 32'(s_we_o), 32'(eg == 2'd0));
    chk({nm, "_swdata"}, s_data_o, wdata_of(eg));
    // Winner drops its request and scribbles its inputs; the latch must hold.
    case (eg)
      2'd0: begin m0_req_i = 1'b0; m0_addr_i = '1; m0_data_i = '1; m0_we_i = 1'b0; end
      2'd1: begin m1_req_i = 1'b0; m1_addr_i = '1; m1_data_i = '1; m1_we_i = 1'b1; end
      default: begin m2_req_i = 1'b0; m2_addr_i = '1; end
    endcase
    #1;
    chk({nm, "_hold_busy"}, 32'(hold_flag_o), 32'(m0_req_i | m1_req_i | (eg != 2'd2)));
    timed = !(ack_cyc >= 1 && ack_cyc <= TMO);
    len = timed ? TMO : ack_cyc;
    bad = 0;
    for (int k = 1; k <= len; k++) begin
      if (s_req_o !== 1'b1 || s_addr_o !== addr_of(eg) || |{m2_ack_o, m1_ack_o, m0_ack_o}) bad++;
      if (k == ack_cyc) begin s_ack_i = 1'b1; s_data_i = rdata; end
      tick();
      s_ack_i = 1'b0; s_data_i = $urandom;
    end
    chk({nm, "_busy_len"}, 32'(bad), 32'd0);
    rd = timed ? 32'd0 : rdata;
    exp_data[eg] = rd;
    s_ack_i = 1'b1;
    chk({nm, "_acks"}, 32'({m2_ack_o, m1_ack_o, m0_ack_o}), 32'(3'b001 << eg));
    chk({nm, "_err"}, 32'(err_o), 32'(timed));
    chk({nm, "_d0"}, m0_data_o, exp_data[0]);
    chk({nm, "_d1"}, m1_data_o, exp_data[1]);
    chk({nm, "_d2"}, m2_data_o, exp_data[2]);
    chk({nm, "_sreq_resp"}, 32'({s_req_o, s_we_o}), 32'd0);
    tick();
    s_ack_i = 1'b0;
    check_idle_outputs({nm, "_after"});
    restore_masters();
  endtask

  initial begin
    tbl[0] = '{3'b010, 32'hDEAD_BEEF, 2'd1, 1};
    tbl[1] = '{3'b111, 32'h0101_0101, 2'd0, 1};
    tbl[2] = '{3'b110, 32'h0202_0202, 2'd1, 3};
    tbl[3] = '{3'b100, 32'h0303_0303, 2'd2, 2};
    tbl[4] = '{3'b001, 32'h0404_0404, 2'd0, 5};
    tbl[5] = '{3'b011, 32'h0505_0505, 2'd0, 1};
    tbl[6] = '{3'b101, 32'h0606_0606, 2'd0, 2};
    tbl[7] = '{3'b100, 32'h0707_0707, 2'd2, 1};

    rst = 1'b1; s_ack_i = 1'b0; s_data_i = '0;
    m0_req_i = 1'b0; m1_req_i = 1'b0; m2_req_i = 1'b0;
    restore_masters();
    foreach (exp_data[i]) exp_data[i] = '0;
    tick(); tick();
    check_idle_outputs("reset");
    chk("reset_data", m0_data_o | m1_data_o | m2_data_o | s_addr_o | s_data_o, 32'd0);
    chk("reset_hold", 32'(hold_flag_o), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_txn(tbl[i].req, tbl[i].rdata, tbl[i].gnt, tbl[i].ack, $sformatf("vec%0d", i));

    run_txn(3'b010, 32'h1234_5678, 2'd1, 0, "timeout");
    run_txn(3'b001, 32'h55AA_55AA, 2'd0, TMO, "ack_at_tmo");

    // Ack while idle with no request must not start anything.
    s_ack_i = 1'b1; s_data_i = 32'hFFFF_0000;
    tick();
    s_ack_i = 1'b0;
    check_idle_outputs("idle_ack");

    rst = 1'b1; tick(); rst = 1'b0;
    foreach (exp_data[i]) exp_data[i] = '0;
    for (int i = 1; i <= 10; i++)
      run_txn(3'b110, 32'(i), (i == 9) ? 2'd2 : 2'd1, 1, $sformatf("starve%0d", i));

    // Reset during BUSY cycle 3, with a slave ack arriving at the same time.
    m0_req_i = 1'b1; m1_req_i = 1'b0; m2_req_i = 1'b0;
    tick();
    m0_req_i = 1'b0;
    tick(); tick();
    chk("midrst_busy3", 32'(s_req_o), 32'd1);
    rst = 1'b1; s_ack_i = 1'b1; s_data_i = 32'hCAFE_F00D;
    tick();
    rst = 1'b0; s_ack_i = 1'b0;
    check_idle_outputs("midrst");
    chk("midrst_data", m0_data_o | m1_data_o | m2_data_o, 32'd0);
    tick();
    check_idle_outputs("midrst_next");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
